// File: rtl/kgp_prefix_adder_pipe.sv
// kgp_prefix_adder_pipe
//   Pipelined Kogge-Stone prefix adder/subtractor with a valid/ready stream
//   interface and a single global stall.
//
//   Stage 0 registers the per-bit generate/propagate (KGP) vectors.
//   Next come log2(WIDTH) prefix levels, which are either combinational or
//   each registered (PIPE_PREFIX). The last stage registers sum/cout/ovf/zero.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand beat handshake; in_ready = ~out_valid | out_ready
//   a, b, cin, sub      operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready result beat handshake
//   sum, cout, ovf, zero result modulo 2^WIDTH, carry out (no-borrow on sub),
//                       signed overflow, sum==0

module kgp_prefix_adder_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_PREFIX = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int L = $clog2(WIDTH);   // prefix levels
    localparam int N = WIDTH + 1;       // positions: 0 = carry-in, i+1 = bit i

    // One stall signal for the whole pipe. in_ready follows out_ready
    // combinationally; there is no skid buffer.
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // ------------------------------------------------------------------
    // Stage 0: KGP generation
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [N-1:0]     g0_d, p0_d;

    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub | cin;              // subtract forces carry-in of 1
        g0_d  = {a & b_eff, c0};
        p0_d  = {a ^ b_eff, 1'b0};
    end

    logic [N-1:0] g0_q, p0_q;
    logic         v0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  v0_q <= 1'b0;
        else if (en) v0_q <= in_valid;
    end

    // Data registers need no reset: contents of an invalid stage are don't-care.
    always_ff @(posedge clk) begin
        if (en && in_valid) begin
            g0_q <= g0_d;
            p0_q <= p0_d;
        end
    end

    // ------------------------------------------------------------------
    // Prefix levels. h carries the original half-sum bits p[WIDTH:1]
    // alongside the tree so the final XOR has them at the right stage.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < L; k++) begin : g_lvl
        logic [N-1:0]     g_in, p_in, g_nx, p_nx, g_out, p_out;
        logic [WIDTH-1:0] h_in, h_out;
        logic             v_in, v_out;

        if (k == 0) begin : g_src
            assign g_in = g0_q;
            assign p_in = p0_q;
            assign h_in = p0_q[N-1:1];
            assign v_in = v0_q;
        end else begin : g_src
            assign g_in = g_lvl[k-1].g_out;
            assign p_in = g_lvl[k-1].p_out;
            assign h_in = g_lvl[k-1].h_out;
            assign v_in = g_lvl[k-1].v_out;
        end

        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_op
                assign g_nx[i] = g_in[i] | (p_in[i] & g_in[i-(1<<k)]);
                assign p_nx[i] = p_in[i] & p_in[i-(1<<k)];
            end else begin : g_pass
                assign g_nx[i] = g_in[i];
                assign p_nx[i] = p_in[i];
            end
        end

        if (PIPE_PREFIX != 0) begin : g_reg
            logic [N-1:0]     g_q, p_q;
            logic [WIDTH-1:0] h_q;
            logic             v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  v_q <= 1'b0;
                else if (en) v_q <= v_in;
            end

            always_ff @(posedge clk) begin
                if (en && v_in) begin
                    g_q <= g_nx;
                    p_q <= p_nx;
                    h_q <= h_in;
                end
            end

            assign g_out = g_q;
            assign p_out = p_q;
            assign h_out = h_q;
            assign v_out = v_q;
        end else begin : g_comb
            assign g_out = g_nx;
            assign p_out = p_nx;
            assign h_out = h_in;
            assign v_out = v_in;
        end
    end

    // ------------------------------------------------------------------
    // Final stage
    // ------------------------------------------------------------------
    logic [N-1:0]     gf, pf;
    logic [WIDTH-1:0] hf;
    logic             vf;

    assign gf = g_lvl[L-1].g_out;
    assign pf = g_lvl[L-1].p_out;
    assign hf = g_lvl[L-1].h_out;
    assign vf = g_lvl[L-1].v_out;

    // Only the top group-propagate feeds the carry-out fix-up below.
    logic unused_pf;
    assign unused_pf = ^pf[WIDTH-1:0];

    logic [WIDTH-1:0] sum_d;
    logic             cout_d, ovf_d, zero_d;

    // log2(WIDTH) levels span exactly WIDTH positions, so gf[i] is the full
    // carry for i < WIDTH. The top position (WIDTH+1 positions in total)
    // still lacks position 0. One more operator step folds the carry-in in.
    always_comb begin
        sum_d  = hf ^ gf[WIDTH-1:0];
        cout_d = gf[WIDTH] | (pf[WIDTH] & gf[0]);
        ovf_d  = cout_d ^ gf[WIDTH-1];
        zero_d = ~|sum_d;
    end

    logic [WIDTH-1:0] sum_q;
    logic             out_valid_q, cout_q, ovf_q, zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (en) begin
            out_valid_q <= vf;
            if (vf) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_kgp_prefix_adder_pipe.sv
// Scoreboard bench: four builds (32/comb, 32/piped, 8/comb, 64/comb) share
// the operand bus and each has its own in_valid/out_ready. Expected results
// are queued at acceptance; one monitor per DUT pops on every delivered beat.
module tb_kgp_prefix_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  iv, or_r, rdy, ov, co, of, zr;
    logic [63:0] a_s, b_s;
    logic        cin_s, sub_s;
    logic [31:0] s0, s1;
    logic [7:0]  s2;
    logic [63:0] s3;
    logic [66:0] act [4];
    logic [66:0] q [4][$];

    int checks = 0, errors = 0, got0 = 0;
    logic tog_en = 1'b0;

    kgp_prefix_adder_pipe #(.WIDTH(32), .PIPE_PREFIX(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
        .a(a_s[31:0]), .b(b_s[31:0]), .cin(cin_s), .sub(sub_s),
        .out_valid(ov[0]), .out_ready(or_r[0]), .sum(s0),
        .cout(co[0]), .ovf(of[0]), .zero(zr[0]));
    kgp_prefix_adder_pipe #(.WIDTH(32), .PIPE_PREFIX(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
        .a(a_s[31:0]), .b(b_s[31:0]), .cin(cin_s), .sub(sub_s),
        .out_valid(ov[1]), .out_ready(or_r[1]), .sum(s1),
        .cout(co[1]), .ovf(of[1]), .zero(zr[1]));
    kgp_prefix_adder_pipe #(.WIDTH(8), .PIPE_PREFIX(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
        .a(a_s[7:0]), .b(b_s[7:0]), .cin(cin_s), .sub(sub_s),
        .out_valid(ov[2]), .out_ready(or_r[2]), .sum(s2),
        .cout(co[2]), .ovf(of[2]), .zero(zr[2]));
    kgp_prefix_adder_pipe #(.WIDTH(64), .PIPE_PREFIX(0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(rdy[3]),
        .a(a_s), .b(b_s), .cin(cin_s), .sub(sub_s),
        .out_valid(ov[3]), .out_ready(or_r[3]), .sum(s3),
        .cout(co[3]), .ovf(of[3]), .zero(zr[3]));

    // {zero, ovf, cout, sum zero-extended to 64}
    assign act[0] = {zr[0], of[0], co[0], 32'd0, s0};
    assign act[1] = {zr[1], of[1], co[1], 32'd0, s1};
    assign act[2] = {zr[2], of[2], co[2], 56'd0, s2};
    assign act[3] = {zr[3], of[3], co[3], s3};

    function automatic logic [66:0] mk(logic z, logic o, logic c, logic [63:0] s);
        return {z, o, c, s};
    endfunction

    // Reference: plain wide addition, independent of any prefix structure.
    function automatic logic [66:0] model(int w, logic [63:0] av, logic [63:0] bv,
                                          logic ci, logic su);
        logic [63:0] m, aa, bb, s;
        logic [64:0] r;
        logic        c, o;
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aa = av & m;
        bb = (su ? ~bv : bv) & m;
        r  = {1'b0, aa} + {1'b0, bb} + {64'd0, (su | ci)};
        s  = r[63:0] & m;
        c  = r[w];
        o  = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
        return {(s == 64'd0), o, c, s};
    endfunction

    // Monitors: compare on every delivered beat, and check outputs hold
    // steady across any cycle where a result was stalled.
    for (genvar k = 0; k < 4; k++) begin : g_mon
        logic        hold = 1'b0;
        logic [66:0] held, e;
        always @(negedge clk) begin
            if (!rst_n) hold = 1'b0;
            else begin
                if (hold) begin
                    checks++;
                    if (act[k] !== held) begin
                        errors++;
                        $display("FAIL stall_hold dut%0d got %h want %h", k, act[k], held);
                    end
                end
                hold = ov[k] && !or_r[k];
                held = act[k];
                if (ov[k] && or_r[k]) begin
                    checks++;
                    if (q[k].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out dut%0d got %h want none", k, act[k]);
                    end else begin
                        e = q[k].pop_front();
                        if (act[k] !== e) begin
                            errors++;
                            $display("FAIL result dut%0d got %h want %h", k, act[k], e);
                        end
                        if (k == 0) got0++;
                    end
                end
            end
        end
    end

    // Pseudo-random backpressure on the two 32-bit builds.
    always @(posedge clk) begin
        #1;
        if (tog_en) or_r[1:0] = 2'($urandom_range(0, 3));
    end

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic send(int id, logic [63:0] av, logic [63:0] bv, logic ci, logic su,
                        logic [66:0] e);
        a_s = av; b_s = bv; cin_s = ci; sub_s = su;
        iv[id] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rdy[id]) begin
                q[id].push_back(e);
                @(posedge clk); #1;
                iv[id] = 1'b0;
                a_s = {$urandom(), $urandom()};   // idle garbage must be ignored
                b_s = {$urandom(), $urandom()};
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL send_timeout dut%0d got no in_ready want accept", id);
        iv[id] = 1'b0;
    endtask

    task automatic rnd(int id, int w);
        logic [63:0] av, bv;
        logic ci, su;
        av = {$urandom(), $urandom()};
        bv = {$urandom(), $urandom()};
        ci = 1'($urandom_range(0, 1));
        su = 1'($urandom_range(0, 1));
        send(id, av, bv, ci, su, model(w, av, bv, ci, su));
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 1000; t++) begin
            if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) break;
            @(posedge clk); #1;
        end
        if (t == 1000) begin
            checks++; errors++;
            $display("FAIL drain_timeout got %0d pending want 0",
                     q[0].size() + q[1].size() + q[2].size() + q[3].size());
        end
    endtask

    // Counts edges from the accept edge until out_valid is first seen.
    task automatic lat_check(int id, int want);
        int n;
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (ov[id]) break;
            @(posedge clk);
        end
        checks++;
        if (n != want) begin
            errors++;
            $display("FAIL latency dut%0d got %0d want %0d", id, n, want);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0; iv = '0; or_r = 4'hF;
        a_s = '0; b_s = '0; cin_s = 1'b0; sub_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || act[k] !== 67'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d got %b/%h want 0/0", k, ov[k], act[k]);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed 32-bit vectors, back-to-back.
        send(0, 64'hFFFFFFFF, 64'h1,        1'b0, 1'b0, mk(1, 0, 1, 64'h0));
        send(0, 64'h7FFFFFFF, 64'h1,        1'b0, 1'b0, mk(0, 1, 0, 64'h80000000));
        send(0, 64'h5,        64'h7,        1'b0, 1'b1, mk(0, 0, 0, 64'hFFFFFFFE));
        send(0, 64'hFFFFFFFF, 64'h0,        1'b1, 1'b0, mk(1, 0, 1, 64'h0));
        send(0, 64'h7,        64'h5,        1'b0, 1'b1, mk(0, 0, 1, 64'h2));
        send(0, 64'h80000000, 64'h1,        1'b0, 1'b1, mk(0, 1, 1, 64'h7FFFFFFF));
        send(0, 64'h5,        64'h5,        1'b1, 1'b1, mk(1, 0, 1, 64'h0));
        send(0, 64'h12345678, 64'h11111111, 1'b1, 1'b0, mk(0, 0, 0, 64'h2345678A));
        drain();

        // Latency, both prefix styles.
        send(0, 64'h3, 64'h4, 1'b0, 1'b0, mk(0, 0, 0, 64'h7));
        lat_check(0, 2);
        drain();
        send(1, 64'h12345678, 64'h11111111, 1'b1, 1'b0, mk(0, 0, 0, 64'h2345678A));
        lat_check(1, 7);
        drain();

        // Streams under random backpressure.
        base = got0;
        tog_en = 1'b1;
        for (int i = 0; i < 16; i++) rnd(0, 32);
        for (int i = 0; i < 16; i++) rnd(1, 32);
        drain();
        tog_en = 1'b0;
        @(posedge clk); #2 or_r = 4'hF;
        checks++;
        if (got0 - base != 16) begin
            errors++;
            $display("FAIL stream_count got %0d want 16", got0 - base);
        end

        // 8-bit build.
        send(2, 64'hFF, 64'h01, 1'b0, 1'b0, mk(1, 0, 1, 64'h0));
        send(2, 64'h7F, 64'h01, 1'b0, 1'b0, mk(0, 1, 0, 64'h80));
        send(2, 64'h05, 64'h07, 1'b0, 1'b1, mk(0, 0, 0, 64'hFE));
        send(2, 64'h80, 64'h01, 1'b0, 1'b1, mk(0, 1, 1, 64'h7F));
        for (int i = 0; i < 1500; i++) rnd(2, 8);
        drain();

        // 64-bit build.
        send(3, 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, mk(1, 0, 1, 64'h0));
        send(3, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, mk(0, 1, 0, 64'h8000000000000000));
        send(3, 64'h5, 64'h7, 1'b0, 1'b1, mk(0, 0, 0, 64'hFFFFFFFFFFFFFFFE));
        send(3, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b0, mk(1, 0, 1, 64'h0));
        for (int i = 0; i < 1500; i++) rnd(3, 64);
        drain();

        // Reset with two beats in flight in the piped build.
        send(1, 64'h10, 64'h20, 1'b0, 1'b0, mk(0, 0, 0, 64'h30));
        send(1, 64'h11, 64'h22, 1'b0, 1'b0, mk(0, 0, 0, 64'h33));
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || act[k] !== 67'd0) begin
                errors++;
                $display("FAIL async_reset dut%0d got %b/%h want 0/0", k, ov[k], act[k]);
            end
            q[k].delete();
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);   // any stale beat trips unexpected_out
        #1;
        send(1, 64'h1, 64'h2, 1'b0, 1'b0, mk(0, 0, 0, 64'h3));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
